// File: rtl/sync_calibration_sequencer.sv
// Burst calibration sequencer: fast-gate armed, phase aligned trigger shots
// with a detector-ready handshake and timeout.
module sync_calibration_sequencer #(
   parameter int NUM_CH    = 4,
   parameter int DELAY_W   = 24,
   parameter int SHOTS_W   = 8,
   parameter int PULSE_W   = 8,
   parameter int TIMEOUT   = 2**22,
   parameter int DET_GRACE = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start_signal,
   input  logic               abort,
   input  logic               fg_signal,
   input  logic               phase_signal,
   input  logic               detector_ready,
   input  logic [DELAY_W-1:0] cfg_delay,
   input  logic [SHOTS_W-1:0] cfg_shots,
   input  logic [PULSE_W-1:0] cfg_pulse_len,
   input  logic [NUM_CH-1:0]  cfg_ch_enable,
   output logic [NUM_CH-1:0]  output_trigger,
   output logic [2:0]         scenario_state,
   output logic [SHOTS_W-1:0] counter_out,
   output logic               busy,
   output logic               done,
   output logic               error
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [TMO_W-1:0] GRACE    = TMO_W'(DET_GRACE);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_DELAY = 3'd2,
      S_PHASE = 3'd3,
      S_FIRE  = 3'd4,
      S_WAIT  = 3'd5,
      S_DONE  = 3'd6,
      S_ERROR = 3'd7
   } state_t;

   state_t state;

   logic [3:0] sync1;
   logic [3:0] sync2;
   logic [2:0] prev;
   logic [2:0] rise;
   logic       start_rise;
   logic       fg_rise;
   logic       phase_rise;
   logic       ready_sync;

   logic [DELAY_W-1:0] lat_delay;
   logic [SHOTS_W-1:0] lat_shots;
   logic [PULSE_W-1:0] lat_pulse;
   logic [NUM_CH-1:0]  lat_mask;
   logic [DELAY_W-1:0] delay_cnt;
   logic [PULSE_W-1:0] pulse_cnt;
   logic [TMO_W-1:0]   wait_cnt;

   // bit 3 (detector ready) is used as a level, the others as edges
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= {detector_ready, phase_signal, fg_signal, start_signal};
         sync2 <= sync1;
         prev  <= sync2[2:0];
      end
   end

   assign rise       = sync2[2:0] & ~prev;
   assign start_rise = rise[0];
   assign fg_rise    = rise[1];
   assign phase_rise = rise[2];
   assign ready_sync = sync2[3];

   assign scenario_state = state;

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= S_IDLE;
         output_trigger <= '0;
         counter_out    <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
         lat_delay      <= '0;
         lat_shots      <= '0;
         lat_pulse      <= '0;
         lat_mask       <= '0;
         delay_cnt      <= '0;
         pulse_cnt      <= '0;
         wait_cnt       <= '0;
      end else if (abort) begin
         state          <= S_IDLE;
         output_trigger <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start_rise) begin
                  lat_delay   <= cfg_delay;
                  lat_shots   <= cfg_shots;
                  lat_mask    <= cfg_ch_enable;
                  lat_pulse   <= (cfg_pulse_len == '0) ?
                                 PULSE_W'(1) : cfg_pulse_len;
                  counter_out <= '0;
                  busy        <= 1'b1;
                  if (cfg_shots == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_ARM;
                  end
               end
            end
            S_ARM: begin
               if (fg_rise) begin
                  if (lat_delay == '0) begin
                     state <= S_PHASE;
                  end else begin
                     state     <= S_DELAY;
                     delay_cnt <= lat_delay;
                  end
               end
            end
            S_DELAY: begin
               if (delay_cnt == DELAY_W'(1)) begin
                  state <= S_PHASE;
               end else begin
                  delay_cnt <= delay_cnt - DELAY_W'(1);
               end
            end
            S_PHASE: begin
               if (phase_rise) begin
                  state          <= S_FIRE;
                  output_trigger <= lat_mask;
                  pulse_cnt      <= lat_pulse;
                  counter_out    <= counter_out + SHOTS_W'(1);
               end
            end
            S_FIRE: begin
               if (pulse_cnt == PULSE_W'(1)) begin
                  state          <= S_WAIT;
                  output_trigger <= '0;
                  wait_cnt       <= '0;
               end else begin
                  pulse_cnt <= pulse_cnt - PULSE_W'(1);
               end
            end
            S_WAIT: begin
               // ready wins over a timeout landing on the same cycle
               if (wait_cnt >= GRACE && ready_sync) begin
                  if (counter_out == lat_shots) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_ARM;
                  end
               end else if (wait_cnt == TMO_LAST) begin
                  state <= S_ERROR;
                  error <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + TMO_W'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            S_ERROR: begin
               error <= 1'b1;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sync_calibration_sequencer.sv
// Randomised bench for sync_calibration_sequencer against a timeline model
// of the shot sequence, plus directed scenarios with literal expectations.
module tb_sync_calibration_sequencer;

   localparam int TMO   = 1000;
   localparam int GRACE = 16;

   logic       clock;
   logic       reset;
   logic       start_signal;
   logic       abort;
   logic       fg_signal;
   logic       phase_signal;
   logic       detector_ready;
   logic [23:0] cfg_delay;
   logic [7:0]  cfg_shots;
   logic [7:0]  cfg_pulse_len;
   logic [3:0]  cfg_ch_enable;
   logic [3:0]  output_trigger;
   logic [2:0]  scenario_state;
   logic [7:0]  counter_out;
   logic        busy;
   logic        done;
   logic        error;

   sync_calibration_sequencer #(
      .NUM_CH(4), .DELAY_W(24), .SHOTS_W(8), .PULSE_W(8),
      .TIMEOUT(TMO), .DET_GRACE(GRACE)
   ) dut (
      .clock(clock), .reset(reset),
      .start_signal(start_signal), .abort(abort),
      .fg_signal(fg_signal), .phase_signal(phase_signal),
      .detector_ready(detector_ready),
      .cfg_delay(cfg_delay), .cfg_shots(cfg_shots),
      .cfg_pulse_len(cfg_pulse_len), .cfg_ch_enable(cfg_ch_enable),
      .output_trigger(output_trigger), .scenario_state(scenario_state),
      .counter_out(counter_out), .busy(busy), .done(done), .error(error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // ---------------- input generators ----------------
   bit gen_on = 0;
   bit fg_force = 0;
   bit ph_force = 0;
   int rdy_mode = 1;

   initial begin : gen
      fg_signal = 0;
      phase_signal = 0;
      detector_ready = 0;
      forever begin
         @(posedge clock);
         #($urandom_range(2, 8));
         if (gen_on) begin
            if ($urandom_range(0, 7) == 0) fg_signal = ~fg_signal;
            if ($urandom_range(0, 5) == 0) phase_signal = ~phase_signal;
         end else begin
            fg_signal = fg_force;
            phase_signal = ph_force;
         end
         case (rdy_mode)
            0: detector_ready = 0;
            1: detector_ready = 1;
            default:
               if ($urandom_range(0, 3) == 0)
                  detector_ready = ~detector_ready;
         endcase
      end
   end

   // ---------------- behavioural model ----------------
   int m_state = 0;
   int m_cnt = 0;
   logic [3:0] m_trig = 0;
   bit kill;
   bit [3:0] hs, hf, hp, hr;
   bit e_start, e_fg, e_ph, r_sync;

   task automatic go(int st, logic [3:0] tr);
      m_state = st;
      m_trig = tr;
   endtask

   // inputs are seen two clocks late through the synchronisers
   task automatic tick();
      @(posedge clock);
      if (reset) begin
         hs = 0; hf = 0; hp = 0; hr = 0;
         kill = 1;
         m_state = 0; m_trig = 0; m_cnt = 0;
      end else begin
         hs = {hs[2:0], start_signal};
         hf = {hf[2:0], fg_signal};
         hp = {hp[2:0], phase_signal};
         hr = {hr[2:0], detector_ready};
         kill = abort;
      end
      e_start = hs[2] & ~hs[3];
      e_fg = hf[2] & ~hf[3];
      e_ph = hp[2] & ~hp[3];
      r_sync = hr[2];
   endtask

   task automatic burst();
      int shots, dly, plen, w;
      logic [3:0] msk;
      shots = int'(cfg_shots);
      dly = int'(cfg_delay);
      plen = (cfg_pulse_len == 0) ? 1 : int'(cfg_pulse_len);
      msk = cfg_ch_enable;
      m_cnt = 0;
      if (shots == 0) begin
         go(6, 0);
         tick();
         return;
      end
      forever begin
         go(1, 0);
         do begin tick(); if (kill) return; end while (!e_fg);
         if (dly > 0) begin
            go(2, 0);
            repeat (dly) begin tick(); if (kill) return; end
         end
         go(3, 0);
         do begin tick(); if (kill) return; end while (!e_ph);
         m_cnt++;
         go(4, msk);
         repeat (plen) begin tick(); if (kill) return; end
         go(5, 0);
         w = 0;
         forever begin
            tick();
            if (kill) return;
            if (w >= GRACE && r_sync) break;
            if (w == TMO - 1) begin
               go(7, 0);
               forever begin tick(); if (kill) return; end
            end
            w++;
         end
         if (m_cnt == shots) begin
            go(6, 0);
            tick();
            return;
         end
      end
   endtask

   initial begin : model
      forever begin
         go(0, 0);
         tick();
         if (!kill && e_start) burst();
      end
   end

   // ---------------- compare process ----------------
   int pin_seq = 0;
   string p_nm;
   int p_st, p_cnt, p_tr, p_er, p_dn;
   int tmo_seq = 0;
   string tmo_nm;

   task automatic lit(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   initial begin : cmp
      int last_pin, last_tmo;
      bit eb, ed, ee;
      last_pin = 0;
      last_tmo = 0;
      @(posedge clock);
      forever begin
         @(negedge clock);
         eb = (m_state != 0 && m_state != 7);
         ed = (m_state == 6);
         ee = (m_state == 7);
         checks++;
         if (scenario_state !== 3'(m_state) || counter_out !== 8'(m_cnt)
             || output_trigger !== m_trig || busy !== eb
             || done !== ed || error !== ee) begin
            errors++;
            $display("FAIL cycle t=%0t got st=%0d cnt=%0d trig=%b b=%b d=%b e=%b want st=%0d cnt=%0d trig=%b b=%b d=%b e=%b",
                     $time, scenario_state, counter_out, output_trigger,
                     busy, done, error, m_state, m_cnt, m_trig, eb, ed, ee);
         end
         if (pin_seq != last_pin) begin
            last_pin = pin_seq;
            if (p_st >= 0) lit({p_nm, ".state"}, int'(scenario_state), p_st);
            if (p_cnt >= 0) lit({p_nm, ".count"}, int'(counter_out), p_cnt);
            if (p_tr >= 0) lit({p_nm, ".trig"}, int'(output_trigger), p_tr);
            if (p_er >= 0) lit({p_nm, ".error"}, int'(error), p_er);
            if (p_dn >= 0) lit({p_nm, ".done"}, int'(done), p_dn);
         end
         if (tmo_seq != last_tmo) begin
            last_tmo = tmo_seq;
            checks++;
            errors++;
            $display("FAIL wait %s: got timeout want state reached", tmo_nm);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic pin(string nm, int st, int cnt, int tr, int er, int dn);
      p_nm = nm; p_st = st; p_cnt = cnt; p_tr = tr; p_er = er; p_dn = dn;
      pin_seq++;
   endtask

   task automatic wait_st(int st, int lim, string nm);
      int n;
      n = 0;
      while (m_state != st && n < lim) begin cyc(1); n++; end
      if (m_state != st) begin tmo_nm = nm; tmo_seq++; end
   endtask

   task automatic kick();
      start_signal = 1;
      cyc(2);
      start_signal = 0;
   endtask

   task automatic cfg(int sh, int dl, int pl, int mk);
      cfg_shots = 8'(sh);
      cfg_delay = 24'(dl);
      cfg_pulse_len = 8'(pl);
      cfg_ch_enable = 4'(mk);
   endtask

   initial begin : stim
      int n;
      reset = 1;
      start_signal = 0;
      abort = 0;
      cfg(0, 0, 0, 0);
      cyc(3);
      reset = 0;
      cyc(2);
      pin("reset", 0, 0, 0, 0, 0);

      // 1: three shots, 4-cycle pulses on ch0/ch2
      gen_on = 1; rdy_mode = 1;
      cfg(3, 100, 4, 4'b0101);
      kick();
      wait_st(6, 3000, "t1_done");
      pin("t1_done", 6, 3, 0, 0, 1);
      cyc(1);
      pin("t1_idle", 0, 3, 0, 0, 0);

      // 2: zero delay, deterministic edges
      gen_on = 0; fg_force = 0; ph_force = 0;
      cfg(1, 0, 3, 4'b1010);
      cyc(4);
      kick();
      wait_st(1, 50, "t2_arm");
      cyc(2);
      fg_force = 1;
      cyc(2);
      pin("t2_arm", 1, 0, 0, 0, 0);
      cyc(1);
      pin("t2_phase", 3, 0, 0, 0, 0);
      cyc(3);
      ph_force = 1;
      cyc(2);
      pin("t2_prefire", 3, 0, 0, 0, 0);
      cyc(1);
      pin("t2_fire", 4, 1, 10, 0, 0);
      wait_st(0, 200, "t2_idle");
      pin("t2_end", 0, 1, 0, 0, 0);
      fg_force = 0; ph_force = 0;
      cyc(4);

      // 3: zero shots
      cfg(0, 7, 2, 4'b1111);
      start_signal = 1;
      cyc(3);
      pin("t3_done", 6, 0, 0, 0, 1);
      cyc(1);
      pin("t3_idle", 0, 0, 0, 0, 0);
      start_signal = 0;
      cyc(3);

      // 4: detector never ready -> timeout error
      gen_on = 1; rdy_mode = 0;
      cfg(2, 5, 2, 4'b0011);
      kick();
      wait_st(7, 3000, "t4_error");
      pin("t4_error", 7, 1, 0, 1, 0);
      kick();
      cyc(6);
      pin("t4_ignore", 7, 1, 0, 1, 0);
      abort = 1;
      cyc(1);
      abort = 0;
      pin("t4_abort", 0, 1, 0, 0, 0);

      // 5: abort during the second shot's pulse
      rdy_mode = 1;
      cfg(5, 10, 6, 4'b0110);
      kick();
      n = 0;
      while (!(m_state == 4 && m_cnt == 2) && n < 5000) begin cyc(1); n++; end
      if (!(m_state == 4 && m_cnt == 2)) begin tmo_nm = "t5_fire"; tmo_seq++; end
      abort = 1;
      cyc(1);
      abort = 0;
      pin("t5_abort", 0, 2, 0, 0, 0);
      cyc(3);
      pin("t5_hold", 0, 2, 0, 0, 0);

      // 6: restart and cfg change mid-burst are ignored
      rdy_mode = 2;
      cfg(2, 20, 3, 4'b1111);
      kick();
      wait_st(2, 500, "t6_delay");
      cfg(7, 3, 1, 4'b0001);
      kick();
      wait_st(0, 5000, "t6_idle");
      pin("t6_end", 0, 2, 0, 0, 0);
      cfg(3, 60, 2, 4'b1001);
      kick();
      wait_st(2, 500, "t6_delay2");
      reset = 1;
      cyc(1);
      reset = 0;
      pin("t6_reset", 0, 0, 0, 0, 0);
      cyc(3);

      // random bursts
      for (int i = 0; i < 12; i++) begin
         rdy_mode = $urandom_range(1, 2);
         cfg($urandom_range(0, 3), $urandom_range(0, 40),
             $urandom_range(0, 5), $urandom_range(0, 15));
         kick();
         cfg($urandom_range(0, 9), $urandom_range(0, 9),
             $urandom_range(0, 9), $urandom_range(0, 15));
         cyc(2);
         if ($urandom_range(0, 3) == 0) begin
            cyc($urandom_range(5, 150));
            abort = 1;
            cyc(1);
            abort = 0;
         end
         n = 0;
         while (m_state != 0 && m_state != 7 && n < 20000) begin cyc(1); n++; end
         if (m_state != 0 && m_state != 7) begin tmo_nm = "rand_idle"; tmo_seq++; end
         if (m_state == 7) begin
            abort = 1;
            cyc(1);
            abort = 0;
         end
         cyc($urandom_range(1, 6));
      end

      cyc(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
